lab4_timer_ctrl: RTL and testbench
==================================

# lab4_timer_ctrl

Sequencing controller for the lab4 mod-CM up/down counter. It holds a preset, loads it into the counter, and paces counting with a prescaler. It runs the counter as a countdown timer (preset → 0) or as a stopwatch (0 → preset), with pause/resume/abort, and flags completion. It sits between the user command inputs and the counter's ena/load/din/dir pins, and reads back the counter's q.

## Interface
- CM, 100: counter modulus; must match the counter instance. Presets saturate to CM-1.
- DIV, 10: prescaler ratio, counter clock cycles per count step; DIV ≥ 2.
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous active-low reset.
- start  in  1  start/resume/restart command, level sampled per cycle.
- stop  in  1  pause/abort command; wins over start when both are high.
- set_valid  in  1  capture set_val into the preset register.
- set_val  in  7  preset value.
- mode  in  1  0 = countdown, 1 = count-up; latched on start from IDLE/DONE.
- cnt_q  in  7  counter output q.
- cnt_ena  out  1  counter ena.
- cnt_load  out  1  counter load, active-low (0 = load din).
- cnt_din  out  7  counter din.
- cnt_dir  out  1  counter dir (1 = up).
- busy  out  1  high in LOAD, RUN, PAUSE.
- done  out  1  one-cycle completion pulse.
- state  out  3  IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.

## Operation
- Registers: state, preset[6:0], mode_r, psc (ceil(log2 DIV) bits), done.
- Reset values: state=IDLE, preset=0, mode_r=0, psc=0, done=0. Outputs at reset: cnt_ena=0, cnt_load=1, cnt_din=0, cnt_dir=0, busy=0.
- Preset capture happens only in IDLE and DONE. It takes effect when set_valid is high: preset <= min(set_val, CM-1). set_valid is ignored in the other states.
- IDLE: cnt_ena=0. On start with stop low: mode_r <= mode, go to LOAD.
- LOAD (exactly 1 cycle): cnt_ena=1, cnt_load=0, cnt_din = mode_r ? 0 : preset. Next state RUN, psc <= 0.
- Target value: countdown target = 0; count-up target = preset.
- RUN:
  - Priority 1: stop → PAUSE, with no step that cycle and psc held.
  - Priority 2: cnt_q == target → DONE, with no step.
  - Otherwise psc increments. When psc == DIV-1: psc <= 0 and a step is issued (cnt_ena=1, cnt_load=1).
- PAUSE: cnt_ena=0, psc frozen. stop → IDLE (abort, psc cleared). start (stop low) → RUN, psc resumes from its held value.
- DONE: cnt_ena=0. done=1 only in the first DONE cycle. stop → IDLE. start (stop low) → mode_r <= mode, LOAD (restart). The counter keeps its final value.
- cnt_dir = mode_r in all states. cnt_din = mode_r ? 0 : preset outside LOAD as well.
- cnt_ena, cnt_load, cnt_din and cnt_dir are combinational decodes of registered state, psc and mode_r. They must not depend combinationally on start, stop or set_*.
- The counter never wraps: the terminal check has priority over stepping, and a step is never issued while cnt_q == target.
- A preset of 0 in either mode completes on the first RUN cycle, with no step.
- Reset mid-operation: everything returns to reset values asynchronously, and cnt_ena drops immediately.

## Timing
- Command latency: start seen in IDLE in cycle n → LOAD in n+1 → RUN in n+2. The counter holds the loaded value from cycle n+2.
- In RUN, steps are issued in RUN cycles DIV-1, 2·DIV-1, … counted from RUN entry (first RUN cycle = 0). cnt_q updates one cycle after each step.
- Countdown from preset P ≥ 1: last step in RUN cycle P·DIV-1, terminal seen in RUN cycle P·DIV, DONE (done=1) in RUN cycle P·DIV+1.
- Count-up to P: the same formula applies.
- Pause cycles extend these figures one-for-one.
- stop acts in the same cycle for the output decode: a step is suppressed even when psc == DIV-1.
- done is registered and high for exactly 1 cycle per completion.

## Test plan
- Reset: assert arst low during RUN with cnt_q=37 → state=0, cnt_ena=0, cnt_load=1, busy=0, done=0 immediately; preset reads 0 after release.
- Countdown, DIV=4: set_val=5, start, mode=0 → LOAD for 1 cycle drives din=5; cnt_q goes 5,4,3,2,1,0, one step per 4 cycles; done pulses in RUN cycle 21; state=4.
- Count-up, DIV=4: preset 3, mode=1 → din=0 loaded, cnt_q goes 0..3, done in RUN cycle 13, cnt_dir=1 throughout, no step at cnt_q=3.
- Saturation and ignore rules: set_val=120 in IDLE → din=99 in LOAD; set_valid=1 with set_val=10 during RUN → preset stays 99.
- Pause/resume/abort: stop at RUN cycle 6 → PAUSE for 10 cycles with cnt_ena=0 and cnt_q and psc frozen; start → steps resume with the original phase; stop in PAUSE → IDLE.
- Edge cases:
  - start and stop high together in IDLE → stays IDLE.
  - Preset 0 → done in the first DONE cycle right after the first RUN cycle, with zero steps.
  - start in DONE → restart through LOAD.

Source files
------------

// File: rtl/lab4_timer_ctrl.sv
// Sequencer for the lab4 mod-CM counter: preset load, prescaled stepping,
// countdown or stopwatch runs with pause/resume/abort and a done pulse.
module lab4_timer_ctrl #(
    parameter int CM  = 100,
    parameter int DIV = 10
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       set_valid_i,
    input  logic [6:0] set_val_i,
    input  logic       mode_i,
    input  logic [6:0] cnt_q_i,
    output logic       cnt_ena_o,
    output logic       cnt_load_o,
    output logic [6:0] cnt_din_o,
    output logic       cnt_dir_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] state_o
);

    localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [6:0]       PRESET_MAX = 7'(CM - 1);
    localparam logic [PSC_W-1:0] PSC_LAST   = PSC_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [6:0]       preset_q, preset_d;
    logic             mode_q, mode_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             done_q, done_d;

    logic [6:0] target;
    logic       at_target;
    logic       step;

    assign target    = mode_q ? preset_q : 7'd0;
    assign at_target = (cnt_q_i == target);
    // stop suppresses a step in the very cycle it is seen; the target check
    // guarantees the counter is never pushed past its end value.
    assign step      = (state_q == RUN) && !stop_i && !at_target && (psc_q == PSC_LAST);

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q  <= IDLE;
            preset_q <= '0;
            mode_q   <= 1'b0;
            psc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            mode_q   <= mode_d;
            psc_q    <= psc_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        mode_d   = mode_q;
        psc_d    = psc_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (set_valid_i)
                    preset_d = (set_val_i > PRESET_MAX) ? PRESET_MAX : set_val_i;
                if (stop_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    mode_d  = mode_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
                psc_d   = '0;
            end
            RUN: begin
                if (stop_i) begin
                    state_d = PAUSE;
                end else if (at_target) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + PSC_W'(1);
                end
            end
            PAUSE: begin
                if (stop_i) begin
                    state_d = IDLE;
                    psc_d   = '0;
                end else if (start_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_ena_o  = (state_q == LOAD) || step;
    assign cnt_load_o = (state_q != LOAD);
    assign cnt_din_o  = mode_q ? 7'd0 : preset_q;
    assign cnt_dir_o  = mode_q;
    assign busy_o     = (state_q == LOAD) || (state_q == RUN) || (state_q == PAUSE);
    assign done_o     = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_lab4_timer_ctrl.sv
// Bench for lab4_timer_ctrl: a mod-CM counter model closes the loop, a
// behavioural reference is compared every cycle, directed runs pin timing.
module tb_lab4_timer_ctrl;

    localparam int CM  = 100;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       start, stop, set_valid, mode;
    logic [6:0] set_val;
    logic [6:0] q = 7'd0;
    logic       cnt_ena, cnt_load, cnt_dir, busy, done_o;
    logic [6:0] cnt_din;
    logic [2:0] state_o;

    int vectors = 0;
    int errors  = 0;

    // reference model: state code, preset, latched mode, RUN progress count
    int m_st = 0, m_pre = 0, m_mode = 0, m_ph = 0, m_done = 0;

    lab4_timer_ctrl #(.CM(CM), .DIV(DIV)) dut (
        .clk_i(clk), .arst_i(arst_n), .start_i(start), .stop_i(stop),
        .set_valid_i(set_valid), .set_val_i(set_val), .mode_i(mode),
        .cnt_q_i(q), .cnt_ena_o(cnt_ena), .cnt_load_o(cnt_load),
        .cnt_din_o(cnt_din), .cnt_dir_o(cnt_dir), .busy_o(busy),
        .done_o(done_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // the counter being controlled: load when load low, else step by dir
    always @(posedge clk) begin
        if (cnt_ena) begin
            if (!cnt_load) q <= cnt_din;
            else if (cnt_dir) q <= (q == 7'(CM - 1)) ? 7'd0 : q + 7'd1;
            else q <= (q == 7'd0) ? 7'(CM - 1) : q - 7'd1;
        end
    end

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_st = 0; m_pre = 0; m_mode = 0; m_ph = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_st == 0 || m_st == 4) begin
                if (set_valid) m_pre = (int'(set_val) > CM - 1) ? CM - 1 : int'(set_val);
                if (stop) m_st = 0;
                else if (start) begin m_mode = int'(mode); m_st = 1; end
            end else if (m_st == 1) begin
                m_st = 2; m_ph = 0;
            end else if (m_st == 2) begin
                if (stop) m_st = 3;
                else if (int'(q) == (m_mode ? m_pre : 0)) begin m_st = 4; m_done = 1; end
                else m_ph++;
            end else if (m_st == 3) begin
                if (stop) begin m_st = 0; m_ph = 0; end
                else if (start) m_st = 2;
            end
        end
    end

    int e_tgt, e_ena;
    always @(negedge clk) begin
        if (arst_n) begin
            e_tgt = m_mode ? m_pre : 0;
            e_ena = (m_st == 1) ||
                    (m_st == 2 && !stop && int'(q) != e_tgt && (m_ph % DIV) == DIV - 1);
            chk("state", int'(state_o), m_st);
            chk("cnt_ena", int'(cnt_ena), e_ena);
            chk("cnt_load", int'(cnt_load), (m_st == 1) ? 0 : 1);
            chk("cnt_din", int'(cnt_din), m_mode ? 0 : m_pre);
            chk("cnt_dir", int'(cnt_dir), m_mode);
            chk("busy", int'(busy), (m_st >= 1 && m_st <= 3) ? 1 : 0);
            chk("done", int'(done_o), m_done);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_pre(input int v);
        set_valid = 1'b1; set_val = 7'(v);
        cyc();
        set_valid = 1'b0;
    endtask

    task automatic wait_done(inout int n);
        while (!done_o && n < 2000) begin cyc(); n++; end
    endtask

    // start a run; returns din/load seen in LOAD and cycles from start to done
    task automatic run(input logic md, output int n, output int din, output int ld);
        mode = md; start = 1'b1;
        cyc();
        start = 1'b0;
        din = int'(cnt_din); ld = int'(cnt_load);
        n = 1;
        wait_done(n);
    endtask

    int n, din, ld, qh;

    initial begin
        arst_n = 1'b0; start = 0; stop = 0; set_valid = 0; set_val = 0; mode = 0;
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_ena", int'(cnt_ena), 0);
        chk("rst_load", int'(cnt_load), 1);
        chk("rst_din", int'(cnt_din), 0);
        chk("rst_busy", int'(busy), 0);
        #20;
        @(posedge clk); #2 arst_n = 1'b1;
        cyc();

        set_pre(5);
        run(1'b0, n, din, ld);
        chk("cd_load", ld, 0);
        chk("cd_din", din, 5);
        chk("cd_done_cycle", n, 23);
        chk("cd_final_q", int'(q), 0);
        chk("cd_state", int'(state_o), 4);

        set_pre(3);
        run(1'b1, n, din, ld);
        chk("up_din", din, 0);
        chk("up_done_cycle", n, 15);
        chk("up_final_q", int'(q), 3);
        chk("up_dir", int'(cnt_dir), 1);

        set_pre(0);
        run(1'b0, n, din, ld);
        chk("zero_cd_cycle", n, 3);
        run(1'b1, n, din, ld);
        chk("zero_up_cycle", n, 3);

        set_pre(120);
        mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("sat_din", int'(cnt_din), 99);
        set_valid = 1'b1; set_val = 7'd10;
        repeat (5) cyc();
        set_valid = 1'b0;
        n = 6;
        wait_done(n);
        chk("sat_ignore_din", int'(cnt_din), 99);
        chk("sat_done_cycle", n, 99 * DIV + 3);

        set_pre(5);
        mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0; n = 1;
        repeat (7) begin cyc(); n++; end
        stop = 1'b1;
        cyc();
        stop = 1'b0; n++;
        chk("pause_state", int'(state_o), 3);
        qh = int'(q);
        repeat (9) begin cyc(); n++; end
        chk("pause_q_frozen", int'(q), qh);
        start = 1'b1;
        cyc();
        start = 1'b0; n++;
        wait_done(n);
        chk("pause_done_cycle", n, 34);

        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_load", int'(state_o), 1);
        repeat (2) cyc();
        stop = 1'b1; cyc();
        chk("abort_pause", int'(state_o), 3);
        cyc(); stop = 1'b0;
        chk("abort_idle", int'(state_o), 0);

        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", int'(state_o), 0);

        set_pre(50);
        mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (20) cyc();
        #1 arst_n = 1'b0;
        #1;
        chk("arst_state", int'(state_o), 0);
        chk("arst_ena", int'(cnt_ena), 0);
        chk("arst_load", int'(cnt_load), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done_o), 0);
        @(posedge clk); #2 arst_n = 1'b1;
        cyc();
        chk("arst_preset", int'(cnt_din), 0);

        repeat (3000) begin
            start     = ($urandom % 8) == 0;
            stop      = ($urandom % 30) == 0;
            set_valid = ($urandom % 4) == 0;
            set_val   = (($urandom % 10) == 0) ? 7'($urandom_range(0, 127))
                                               : 7'($urandom_range(0, 12));
            mode      = 1'($urandom % 2);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
